// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-style control path:
// state encoding, opcode constants, instruction field slices and the
// branch-offset sign extension helper.
package mips_pkg;

  // EX=3'b011 and RWB=3'b100 are consumed by the register file, so the
  // encoding is fixed.
  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_MEM  = 3'b010,
    S_EX   = 3'b011,
    S_RWB  = 3'b100,
    S_HALT = 3'b101
  } state_t;

  localparam logic [3:0] OP_SW   = 4'd11;
  localparam logic [3:0] OP_BEQ  = 4'd12;
  localparam logic [3:0] OP_LW   = 4'd13;
  localparam logic [3:0] OP_LI   = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RA_MSB  = 7;
  localparam int RA_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 0;

  // Branch offsets are 4-bit two's complement, widened to the PC width.
  function automatic logic [7:0] sext_imm(input logic [3:0] imm);
    return {{4{imm[3]}}, imm};
  endfunction

endpackage

// File: rtl/mips_ctrl_if.sv
// Bus between the control sequencer and the rest of the core: instruction
// fetch handshake, data memory handshake, register-file strobe and the
// decoded instruction fields. The sequencer takes the master side.
interface mips_ctrl_if;

  logic        fetch_req;
  logic        instr_valid;
  logic [15:0] instr;
  logic        alu_zero;
  logic        mem_ack;
  logic [2:0]  current_state;
  logic [3:0]  OPCODE;
  logic [3:0]  RD;
  logic [3:0]  RA;
  logic [3:0]  RB;
  logic [7:0]  pc;
  logic        mem_req;
  logic        mem_we;
  logic        rf_we;
  logic        halted;
  logic        err;

  modport master (
    input  instr_valid, instr, alu_zero, mem_ack,
    output fetch_req, current_state, OPCODE, RD, RA, RB, pc,
           mem_req, mem_we, rf_we, halted, err
  );

  modport slave (
    output instr_valid, instr, alu_zero, mem_ack,
    input  fetch_req, current_state, OPCODE, RD, RA, RB, pc,
           mem_req, mem_we, rf_we, halted, err
  );

endinterface

// File: rtl/mips_ctrl_timeout.sv
// MEM-state wait counter. Counts MEM cycles without an acknowledge and
// flags the cycle on which the wait limit is reached with still no ack,
// so an ack arriving on the limit cycle completes the access normally.
module mips_ctrl_timeout
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic in_mem,
  input  logic mem_ack,
  output logic expired
);

  logic [3:0] wait_cnt;

  // Held at zero outside MEM so every MEM entry starts from a clean count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wait_cnt <= 4'd0;
    else if (!in_mem)
      wait_cnt <= 4'd0;
    else if (!mem_ack)
      wait_cnt <= wait_cnt + 4'd1;
  end

  assign expired = in_mem && !mem_ack && (wait_cnt == 4'(TIMEOUT - 1));

endmodule

// File: rtl/mips_ctrl.sv
// Multi-cycle control sequencer: IF -> ID -> EX -> (MEM) -> (RWB).
// Optional feature: define MEM_TIMEOUT_EN to abort a MEM wait after
// TIMEOUT cycles, setting the sticky err flag and halting.
module mips_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  mips_ctrl_if.master bus
);

  state_t      state;
  logic [15:0] ir;
  logic [7:0]  pc;
  logic [3:0]  opcode;
  logic        mem_expired;

  assign opcode = ir[OPC_MSB:OPC_LSB];

`ifdef MEM_TIMEOUT_EN
  logic err_q;

  mips_ctrl_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .in_mem  (state == S_MEM),
    .mem_ack (bus.mem_ack),
    .expired (mem_expired)
  );

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_q <= 1'b0;
    else if (mem_expired)
      err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  logic unused_timeout;

  // The wait limit has no meaning without the counter.
  assign unused_timeout = (TIMEOUT != 0);
  assign mem_expired    = 1'b0;
  assign bus.err        = 1'b0;
`endif

  // Main sequencer: state, instruction register and program counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IF;
      ir    <= 16'd0;
      pc    <= 8'd0;
    end else begin
      case (state)
        S_IF: begin
          if (bus.instr_valid) begin
            ir    <= bus.instr;
            pc    <= pc + 8'd1;
            state <= S_ID;
          end
        end
        S_ID: state <= S_EX;
        S_EX: begin
          case (opcode)
            OP_SW, OP_LW: state <= S_MEM;
            OP_BEQ: begin
              if (bus.alu_zero)
                pc <= pc + sext_imm(ir[RB_MSB:RB_LSB]);
              state <= S_IF;
            end
            OP_HALT: state <= S_HALT;
            default: state <= S_RWB;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ack)
            state <= (opcode == OP_SW) ? S_IF : S_RWB;
          else if (mem_expired)
            state <= S_HALT;
        end
        S_RWB:   state <= S_IF;
        S_HALT:  state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  assign bus.fetch_req     = (state == S_IF);
  assign bus.mem_req       = (state == S_MEM);
  assign bus.mem_we        = (state == S_MEM) && (opcode == OP_SW);
  assign bus.rf_we         = (state == S_RWB);
  assign bus.halted        = (state == S_HALT);
  assign bus.current_state = state;
  assign bus.pc            = pc;
  assign bus.OPCODE        = ir[OPC_MSB:OPC_LSB];
  assign bus.RD            = ir[RD_MSB:RD_LSB];
  assign bus.RA            = ir[RA_MSB:RA_LSB];
  assign bus.RB            = ir[RB_MSB:RB_LSB];

endmodule

// File: tb/tb_mips_ctrl.sv
// Testbench for mips_ctrl. Each instruction is expanded into the list of
// cycles it should occupy (state, pc, IR, err) from the opcode rules;
// the list is then played against the DUT with randomized don't-care inputs.
module tb_mips_ctrl;

  localparam int TIMEOUT = 15;

  localparam logic [2:0] ST_IF   = 3'd0;
  localparam logic [2:0] ST_ID   = 3'd1;
  localparam logic [2:0] ST_MEM  = 3'd2;
  localparam logic [2:0] ST_EX   = 3'd3;
  localparam logic [2:0] ST_RWB  = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd5;

  typedef struct {
    logic [2:0]  st;
    logic        iv;
    logic [15:0] ins;
    logic        ack;
    logic        az;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        er;
  } cyc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  cyc_t        plan[$];
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic        m_err;
  logic        m_halted;

  mips_ctrl_if bus ();

  mips_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic pushCyc(input logic [2:0] st, input logic iv, input logic [15:0] ins,
                         input logic ack, input logic az);
    cyc_t c;
    c.st = st; c.iv = iv; c.ins = ins; c.ack = ack; c.az = az;
    c.pc = m_pc; c.ir = m_ir; c.er = m_err;
    plan.push_back(c);
  endtask

  // Expand one instruction into its expected cycles.
  task automatic addInstr(input logic [15:0] ins, input int w_if, input int w_mem, input logic az);
    int op;
    int off;
    if (m_halted) return;
    op = int'(ins[15:12]);
    for (int i = 0; i < w_if; i++)
      pushCyc(ST_IF, 1'b0, 16'($urandom), rbit(), rbit());
    pushCyc(ST_IF, 1'b1, ins, rbit(), rbit());
    m_ir = ins;
    m_pc = 8'((int'(m_pc) + 1) % 256);
    pushCyc(ST_ID, rbit(), 16'($urandom), rbit(), rbit());
    pushCyc(ST_EX, rbit(), 16'($urandom), rbit(), (op == 12) ? az : rbit());
    if (op == 12) begin
      off = ins[3] ? int'(ins[3:0]) - 16 : int'(ins[3:0]);
      if (az) m_pc = 8'((int'(m_pc) + off + 256) % 256);
    end else if (op == 15) begin
      m_halted = 1'b1;
    end else if (op == 11 || op == 13) begin
`ifdef MEM_TIMEOUT_EN
      if (w_mem >= TIMEOUT) begin
        for (int i = 0; i < TIMEOUT; i++)
          pushCyc(ST_MEM, rbit(), 16'($urandom), 1'b0, rbit());
        m_err = 1'b1;
        m_halted = 1'b1;
        return;
      end
`endif
      for (int i = 0; i < w_mem; i++)
        pushCyc(ST_MEM, rbit(), 16'($urandom), 1'b0, rbit());
      pushCyc(ST_MEM, rbit(), 16'($urandom), 1'b1, rbit());
      if (op == 13) pushCyc(ST_RWB, rbit(), 16'($urandom), rbit(), rbit());
    end else begin
      pushCyc(ST_RWB, rbit(), 16'($urandom), rbit(), rbit());
    end
  endtask

  task automatic addHalt(input int n);
    for (int i = 0; i < n; i++)
      pushCyc(ST_HALT, rbit(), 16'($urandom), rbit(), rbit());
  endtask

  // Drive n planned cycles (all when n < 0), checking outputs mid-cycle.
  task automatic applyStimulus(input int n);
    cyc_t e;
    int   done = 0;
    while (plan.size() > 0 && (n < 0 || done < n)) begin
      e = plan.pop_front();
      bus.instr_valid = e.iv;
      bus.instr       = e.ins;
      bus.mem_ack     = e.ack;
      bus.alu_zero    = e.az;
      @(negedge clk);
      checkOutput("state", 32'(bus.current_state), 32'(e.st));
      checkOutput("pc", 32'(bus.pc), 32'(e.pc));
      checkOutput("ir", 32'({bus.OPCODE, bus.RD, bus.RA, bus.RB}), 32'(e.ir));
      checkOutput("fetch_req", 32'(bus.fetch_req), 32'(e.st == ST_IF));
      checkOutput("mem_req", 32'(bus.mem_req), 32'(e.st == ST_MEM));
      checkOutput("mem_we", 32'(bus.mem_we), 32'(e.st == ST_MEM && e.ir[15:12] == 4'd11));
      checkOutput("rf_we", 32'(bus.rf_we), 32'(e.st == ST_RWB));
      checkOutput("halted", 32'(bus.halted), 32'(e.st == ST_HALT));
      checkOutput("err", 32'(bus.err), 32'(e.er));
      @(posedge clk);
      #1;
      done++;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_state"}, 32'(bus.current_state), 32'(ST_IF));
    checkOutput({tag, "_pc"}, 32'(bus.pc), 32'd0);
    checkOutput({tag, "_ir"}, 32'({bus.OPCODE, bus.RD, bus.RA, bus.RB}), 32'd0);
    checkOutput({tag, "_fetch_req"}, 32'(bus.fetch_req), 32'd1);
    checkOutput({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    checkOutput({tag, "_rf_we"}, 32'(bus.rf_we), 32'd0);
    checkOutput({tag, "_halted"}, 32'(bus.halted), 32'd0);
    checkOutput({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  task automatic clearModel();
    plan.delete();
    m_pc = 8'd0; m_ir = 16'd0; m_err = 1'b0; m_halted = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr       = 16'hFFFF;
    bus.mem_ack     = 1'b1;
    bus.alu_zero    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    reset = 1'b0;
    clearModel();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] ins;
    clearModel();

    // Directed sequence: ALU, LW with wait, SW, BEQ taken / not taken, HALT.
    doReset();
    addInstr(16'h3123, 0, 0, 1'b0);
    addInstr(16'hD456, 0, 3, 1'b0);
    addInstr(16'hB789, 1, 0, 1'b0);
    addInstr(16'h0111, 0, 0, 1'b0);
    addInstr(16'hE222, 2, 0, 1'b0);
    addInstr(16'hC00E, 0, 0, 1'b1);
    addInstr(16'h5333, 0, 0, 1'b0);
    addInstr(16'hC01E, 0, 0, 1'b0);
    addInstr(16'hF000, 0, 0, 1'b0);
    addHalt(20);
    applyStimulus(-1);

    // Reset in the middle of a long MEM wait aborts at once.
    doReset();
    addInstr(16'h4444, 0, 0, 1'b0);
    addInstr(16'hD555, 0, 10, 1'b0);
    applyStimulus(9);
    #2;
    reset = 1'b1;
    #1;
    checkResetValues("midmem");
    clearModel();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Long MEM wait: aborts with err when the timeout is built, else waits.
    doReset();
    addInstr(16'hD111, 0, 20, 1'b0);
    if (m_halted) addHalt(3);
    else addInstr(16'h2222, 0, 0, 1'b0);
    applyStimulus(-1);

    // Ack on the last allowed MEM cycle completes normally.
    doReset();
    addInstr(16'hD222, 0, TIMEOUT - 1, 1'b0);
    addInstr(16'hB333, 0, 2, 1'b0);
    addInstr(16'h1444, 0, 0, 1'b0);
    applyStimulus(-1);

    // Random instruction stream, long enough to wrap the pc.
    doReset();
    for (int i = 0; i < 320; i++) begin
      ins = 16'($urandom);
      if (ins[15:12] == 4'd15) ins[15:12] = 4'd14;
      addInstr(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), rbit());
    end
    addInstr(16'hF0F0, 0, 0, 1'b0);
    addHalt(5);
    applyStimulus(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_ctrl.md
# mips_ctrl

Multi-cycle control sequencer for the 8-bit MIPS-style core; it is the producer of the `current_state` and decoded instruction fields consumed by the register file. It fetches 16-bit instructions over a request/valid handshake and walks each instruction through the fetch, decode, execute, memory and register-writeback states. It drives the memory handshake, the register-file write strobe and the program counter.

## Interface
- `TIMEOUT`, default 15: maximum MEM-state wait cycles before abort; only used when `MEM_TIMEOUT_EN` is defined.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_req`  out  1  instruction fetch request at address `pc`.
- `instr_valid`  in  1  `instr` is valid; the transfer completes on any cycle where `fetch_req && instr_valid`.
- `instr`  in  16  instruction word: [15:12] OPCODE, [11:8] RD, [7:4] RA, [3:0] RB/imm.
- `alu_zero`  in  1  ALU zero flag, sampled in EX.
- `mem_ack`  in  1  data memory completion.
- `current_state`  out  3  encoding: IF=000, ID=001, MEM=010, EX=011, RWB=100, HALT=101.
- `OPCODE`, `RD`, `RA`, `RB`  out  4 each  fields of the latched instruction register (IR).
- `pc`  out  8  program counter.
- `mem_req`  out  1  data memory request.
- `mem_we`  out  1  store qualifier for `mem_req`.
- `rf_we`  out  1  register-file write strobe.
- `halted`  out  1  high in HALT.
- `err`  out  1  sticky memory-timeout flag.

## Operation
- Opcodes:
  - 0–10: ALU operations, with writeback.
  - 11: SW, no writeback.
  - 12: BEQ, no writeback.
  - 13: LW, with writeback.
  - 14: LI, with writeback.
  - 15: HALT, no writeback.
- IF:
  - `fetch_req`=1.
  - On handshake: IR <= `instr`, `pc` <= `pc`+1 (mod 256), go to ID.
  - Without a handshake, stay in IF.
- ID: one cycle, during which the register file performs its reads. Always go to EX.
- EX (one cycle):
  - Opcode 11 or 13: go to MEM.
  - Opcode 12: if `alu_zero`, `pc` <= `pc` + sign-extended RB (mod 256). Then go to IF.
  - Opcode 15: go to HALT.
  - All other opcodes: go to RWB.
- MEM:
  - `mem_req`=1; `mem_we`=1 only for opcode 11.
  - Hold MEM until `mem_ack`.
  - On `mem_ack`: SW goes to IF, LW goes to RWB.
  - `mem_ack` outside MEM is ignored.
- RWB: `rf_we`=1 for exactly this one cycle. Go to IF.
- HALT: absorbing state. All request and strobe outputs are 0, `halted`=1. Only reset leaves HALT.
- `rf_we` is never asserted for opcodes 11, 12 or 15, because those opcodes never reach RWB.

## Timing
- Reset values:
  - `current_state`=IF, `pc`=0, IR=0.
  - `fetch_req`=1, since it is decoded from IF.
  - `mem_req`, `mem_we`, `rf_we`, `halted`, `err` = 0.
- Reset mid-instruction aborts immediately (asynchronously); no partial writeback is allowed.
- `fetch_req`, `mem_req`, `mem_we`, `rf_we` and `halted` are Moore outputs, decoded from the registered state only.
- Minimum cycles per instruction, with zero-wait handshakes:
  - ALU/LI: 4.
  - BEQ: 3.
  - SW: 4.
  - LW: 5.
- Each wait cycle on `instr_valid` or `mem_ack` adds one cycle.
- `pc` wraps 255→0 on increment. The branch target is computed in 8 bits with no overflow detection.
- `instr_valid` and `mem_ack` arriving in the same cycle: only the input relevant to the current state is honoured.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A 4-bit wait counter clears on MEM entry and increments each MEM cycle without `mem_ack`.
  - If it reaches `TIMEOUT` without `mem_ack`: `err` <= 1 and go to HALT.
  - `mem_ack` in the same cycle as the limit wins: the access completes normally.
- `MEM_TIMEOUT_EN` undefined: MEM waits indefinitely, `err` is tied to 0, and no counter is built.

## Structure
- The shared package `mips_pkg` holds:
  - the state enum (the existing EX=3'b011 and RWB=3'b100 encodings must match);
  - the opcode constants (OP_SW=11, OP_BEQ=12, OP_LW=13, OP_LI=14, OP_HALT=15);
  - the instruction field slice constants.
- One sub-module, `mips_ctrl_timeout`, contains the MEM wait counter. It is instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- Reset, then a fetch of opcode 3 with `instr_valid` high at once → states IF,ID,EX,RWB; `rf_we` high exactly in cycle 4; `pc`=1.
- LW (opcode 13) with `mem_ack` delayed 3 cycles → MEM held 4 cycles with `mem_req`=1, `mem_we`=0; then RWB with `rf_we`=1.
- SW (opcode 11) → `mem_we`=1 in MEM; no `rf_we` pulse ever; returns to IF.
- BEQ at `pc`=5 with imm=4'hE and `alu_zero`=1 → `pc`=4 after EX. With `alu_zero`=0 → `pc`=6.
- HALT (opcode 15) → `halted`=1 and `fetch_req`=0 held for 20 cycles. Assert `reset` mid-MEM of a later run → immediate IF, `pc`=0.
- With `MEM_TIMEOUT_EN` and `TIMEOUT`=15, LW with no `mem_ack` → `err`=1 and HALT after 15 MEM cycles. `mem_ack` on cycle 15 → normal RWB with `err`=0.
